// File: rtl/wb_int_arbiter.sv
// wb_int_arbiter: shares the single RS Int commit port between the ALU
// (requester 0) and the MDU (requester 1).
//
// Each requester owns a one-entry hold slot. One winner is picked per cycle
// by round-robin and is registered onto commit_*, which gives the same
// one-cycle latency as the integer write-back path. A requester that loses
// from the bypass path parks its result in its slot and wins the next tie.
//
// Optional feature macro: WB_INT_ARB_FLUSH_EN adds the flush input. Flush
// drops both slots and any result accepted in the same cycle.
//
// Ports:
//   clk, rst                  clock; synchronous active-low reset
//   req0_* / req1_*           valid/ready handshake plus rs_addr, exc_type, data
//   flush                     drop all pending results (WB_INT_ARB_FLUSH_EN only)
//   commit_en                 one-cycle commit strobe to RS Int
//   commit_addr/exc_type/data payload of the committed result; holds when idle

`ifndef RS_INT_ADDR_BUS
`define RS_INT_ADDR_BUS [3:0]
`endif
`ifndef EXC_TYPE_BUS
`define EXC_TYPE_BUS [2:0]
`endif
`ifndef DATA_BUS
`define DATA_BUS [31:0]
`endif
`ifndef EXC_TYPE_OV
`define EXC_TYPE_OV 3'd2
`endif

module wb_int_arbiter #(
  parameter int unsigned PRIO_INIT = 0
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  req0_valid,
  output logic                  req0_ready,
  input  logic `RS_INT_ADDR_BUS req0_rs_addr,
  input  logic `EXC_TYPE_BUS    req0_exc_type,
  input  logic `DATA_BUS        req0_data,
  input  logic                  req1_valid,
  output logic                  req1_ready,
  input  logic `RS_INT_ADDR_BUS req1_rs_addr,
  input  logic `EXC_TYPE_BUS    req1_exc_type,
  input  logic `DATA_BUS        req1_data,
`ifdef WB_INT_ARB_FLUSH_EN
  input  logic                  flush,
`endif
  output logic                  commit_en,
  output logic `RS_INT_ADDR_BUS commit_addr,
  output logic `EXC_TYPE_BUS    commit_exc_type,
  output logic `DATA_BUS        commit_data
);

  localparam int unsigned NREQ = 2;
  // last_grant value after reset, so that PRIO_INIT wins the first tie
  localparam logic LAST_GRANT_RST = (PRIO_INIT == 0) ? 1'b1 : 1'b0;

  // Hold slots
  logic [NREQ-1:0]       r_slot_full;
  logic `RS_INT_ADDR_BUS r_slot_addr [NREQ];
  logic `EXC_TYPE_BUS    r_slot_exc  [NREQ];
  logic `DATA_BUS        r_slot_data [NREQ];

  // Arbitration history and registered commit stage
  logic                  r_last_grant;
  logic                  r_commit_en;
  logic `RS_INT_ADDR_BUS r_commit_addr;
  logic `EXC_TYPE_BUS    r_commit_exc;
  logic `DATA_BUS        r_commit_data;

  // Input bus gathered into arrays
  logic [NREQ-1:0]       w_valid;
  logic [NREQ-1:0]       w_ready;
  logic `RS_INT_ADDR_BUS w_in_addr [NREQ];
  logic `EXC_TYPE_BUS    w_in_exc  [NREQ];
  logic `DATA_BUS        w_in_data [NREQ];

  // Per-requester candidate and selected source
  logic [NREQ-1:0]       w_acc;
  logic [NREQ-1:0]       w_cand;
  logic [NREQ-1:0]       w_gnt;
  logic `RS_INT_ADDR_BUS w_src_addr [NREQ];
  logic `EXC_TYPE_BUS    w_src_exc  [NREQ];
  logic `DATA_BUS        w_src_data [NREQ];

  // Winner payload
  logic `RS_INT_ADDR_BUS w_win_addr;
  logic `EXC_TYPE_BUS    w_win_exc;
  logic `DATA_BUS        w_win_data;

  logic                  w_flush;

`ifdef WB_INT_ARB_FLUSH_EN
  assign w_flush = flush;
`else
  assign w_flush = 1'b0;
`endif

  assign w_valid      = {req1_valid, req0_valid};
  assign w_in_addr[0] = req0_rs_addr;
  assign w_in_addr[1] = req1_rs_addr;
  assign w_in_exc[0]  = req0_exc_type;
  assign w_in_exc[1]  = req1_exc_type;
  assign w_in_data[0] = req0_data;
  assign w_in_data[1] = req1_data;

  // Ready depends only on slot occupancy; held low while reset is asserted
  assign w_ready    = {NREQ{rst}} & ~r_slot_full;
  assign req0_ready = w_ready[0];
  assign req1_ready = w_ready[1];

  // Candidate detection and source selection (slot has priority over bypass)
  always_comb begin
    for (int i = 0; i < NREQ; i++) begin
      w_acc[i]  = w_valid[i] & w_ready[i];
      w_cand[i] = r_slot_full[i] | w_acc[i];
      if (r_slot_full[i]) begin
        w_src_addr[i] = r_slot_addr[i];
        w_src_exc[i]  = r_slot_exc[i];
        w_src_data[i] = r_slot_data[i];
      end else begin
        w_src_addr[i] = w_in_addr[i];
        w_src_exc[i]  = w_in_exc[i];
        w_src_data[i] = w_in_data[i];
      end
    end
  end

  // Round-robin: on a tie the requester not granted last time wins
  always_comb begin
    w_gnt    = '0;
    w_gnt[1] = w_cand[1] & (~w_cand[0] | ~r_last_grant);
    w_gnt[0] = w_cand[0] & ~w_gnt[1];
  end

  // Winner payload mux
  always_comb begin
    w_win_addr = w_src_addr[0];
    w_win_exc  = w_src_exc[0];
    w_win_data = w_src_data[0];
    if (w_gnt[1]) begin
      w_win_addr = w_src_addr[1];
      w_win_exc  = w_src_exc[1];
      w_win_data = w_src_data[1];
    end
  end

  // Slots, arbitration history and commit register
  always_ff @(posedge clk) begin
    if (!rst) begin
      r_slot_full   <= '0;
      r_last_grant  <= LAST_GRANT_RST;
      r_commit_en   <= 1'b0;
      r_commit_addr <= '0;
      r_commit_exc  <= '0;
      r_commit_data <= '0;
      for (int i = 0; i < NREQ; i++) begin
        r_slot_addr[i] <= '0;
        r_slot_exc[i]  <= '0;
        r_slot_data[i] <= '0;
      end
    end else if (w_flush) begin
      // Flush beats any grant; last_grant and commit payload are kept
      r_slot_full <= '0;
      r_commit_en <= 1'b0;
    end else begin
      r_commit_en <= |w_gnt;
      if (|w_gnt) begin
        r_commit_addr <= w_win_addr;
        r_commit_exc  <= w_win_exc;
        r_commit_data <= w_win_data;
        r_last_grant  <= w_gnt[1];
      end
      for (int i = 0; i < NREQ; i++) begin
        if (w_gnt[i]) begin
          r_slot_full[i] <= 1'b0;
        end else if (w_acc[i]) begin
          // Lost from the bypass path: park the result until the next cycle
          r_slot_full[i] <= 1'b1;
          r_slot_addr[i] <= w_in_addr[i];
          r_slot_exc[i]  <= w_in_exc[i];
          r_slot_data[i] <= w_in_data[i];
        end
      end
    end
  end

  assign commit_en       = r_commit_en;
  assign commit_addr     = r_commit_addr;
  assign commit_exc_type = r_commit_exc;
  assign commit_data     = r_commit_data;

endmodule

// File: tb/tb_wb_int_arbiter.sv
// Self-checking bench for wb_int_arbiter: directed scenarios plus randomized
// traffic, compared against a queue-based behavioural model.

`ifndef RS_INT_ADDR_BUS
`define RS_INT_ADDR_BUS [3:0]
`endif
`ifndef EXC_TYPE_BUS
`define EXC_TYPE_BUS [2:0]
`endif
`ifndef DATA_BUS
`define DATA_BUS [31:0]
`endif
`ifndef EXC_TYPE_OV
`define EXC_TYPE_OV 3'd2
`endif

module tb_wb_int_arbiter;

  localparam int unsigned PRIO = 0;
`ifdef WB_INT_ARB_FLUSH_EN
  localparam bit FLUSH_ON = 1'b1;
`else
  localparam bit FLUSH_ON = 1'b0;
`endif

  typedef struct packed {
    logic `RS_INT_ADDR_BUS addr;
    logic `EXC_TYPE_BUS    exc;
    logic `DATA_BUS        data;
  } ent_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic                  rst;
  logic                  req0_valid, req0_ready;
  logic `RS_INT_ADDR_BUS req0_rs_addr;
  logic `EXC_TYPE_BUS    req0_exc_type;
  logic `DATA_BUS        req0_data;
  logic                  req1_valid, req1_ready;
  logic `RS_INT_ADDR_BUS req1_rs_addr;
  logic `EXC_TYPE_BUS    req1_exc_type;
  logic `DATA_BUS        req1_data;
`ifdef WB_INT_ARB_FLUSH_EN
  logic                  flush;
`endif
  logic                  commit_en;
  logic `RS_INT_ADDR_BUS commit_addr;
  logic `EXC_TYPE_BUS    commit_exc_type;
  logic `DATA_BUS        commit_data;

  wb_int_arbiter #(.PRIO_INIT(PRIO)) dut (
    .clk             (clk),
    .rst             (rst),
    .req0_valid      (req0_valid),
    .req0_ready      (req0_ready),
    .req0_rs_addr    (req0_rs_addr),
    .req0_exc_type   (req0_exc_type),
    .req0_data       (req0_data),
    .req1_valid      (req1_valid),
    .req1_ready      (req1_ready),
    .req1_rs_addr    (req1_rs_addr),
    .req1_exc_type   (req1_exc_type),
    .req1_data       (req1_data),
`ifdef WB_INT_ARB_FLUSH_EN
    .flush           (flush),
`endif
    .commit_en       (commit_en),
    .commit_addr     (commit_addr),
    .commit_exc_type (commit_exc_type),
    .commit_data     (commit_data)
  );

  int n_tests = 0;
  int n_fail  = 0;

  // Reference model: results accepted but not yet committed, per requester
  ent_t q0[$];
  ent_t q1[$];
  logic m_last;
  logic m_en;
  ent_t m_commit;
  logic m_acc0, m_acc1;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  function automatic ent_t mk(input logic `RS_INT_ADDR_BUS a, input logic `EXC_TYPE_BUS e,
                              input logic `DATA_BUS d);
    ent_t t;
    t.addr = a;
    t.exc  = e;
    t.data = d;
    return t;
  endfunction

  function automatic ent_t rnd_ent();
    return mk(4'($urandom), 3'($urandom), 32'($urandom));
  endfunction

  // One clock cycle: drive at negedge, check ready, step the model,
  // check commit outputs after the edge, return at the next negedge.
  task automatic drive_cycle(input logic r, input logic v0, input ent_t e0,
                             input logic v1, input ent_t e1, input logic fl);
    logic rdy0, rdy1, c0, c1, win, fl_eff;
    ent_t w;
    rst           = r;
    req0_valid    = v0;
    req0_rs_addr  = e0.addr;
    req0_exc_type = e0.exc;
    req0_data     = e0.data;
    req1_valid    = v1;
    req1_rs_addr  = e1.addr;
    req1_exc_type = e1.exc;
    req1_data     = e1.data;
`ifdef WB_INT_ARB_FLUSH_EN
    flush = fl;
`endif
    fl_eff = fl & FLUSH_ON;
    #1;
    rdy0 = r && (q0.size() == 0);
    rdy1 = r && (q1.size() == 0);
    check_eq("ready0", 64'(req0_ready), 64'(rdy0));
    check_eq("ready1", 64'(req1_ready), 64'(rdy1));
    m_acc0 = v0 && rdy0;
    m_acc1 = v1 && rdy1;
    if (!r) begin
      q0.delete();
      q1.delete();
      m_last   = (PRIO == 0);
      m_en     = 1'b0;
      m_commit = '0;
    end else begin
      if (m_acc0) q0.push_back(e0);
      if (m_acc1) q1.push_back(e1);
      if (fl_eff) begin
        q0.delete();
        q1.delete();
        m_en = 1'b0;
      end else begin
        c0  = (q0.size() != 0);
        c1  = (q1.size() != 0);
        win = (c0 && c1) ? !m_last : c1;
        m_en = c0 || c1;
        if (m_en) begin
          if (win) w = q1.pop_front();
          else     w = q0.pop_front();
          m_commit = w;
          m_last   = win;
        end
      end
    end
    @(posedge clk);
    #1;
    check_eq("commit_en",   64'(commit_en),       64'(m_en));
    check_eq("commit_addr", 64'(commit_addr),     64'(m_commit.addr));
    check_eq("commit_exc",  64'(commit_exc_type), 64'(m_commit.exc));
    check_eq("commit_data", 64'(commit_data),     64'(m_commit.data));
    @(negedge clk);
  endtask

  task automatic idle(input logic r);
    drive_cycle(r, 1'b0, '0, 1'b0, '0, 1'b0);
  endtask

  task automatic do_reset();
    idle(1'b0);
    idle(1'b0);
    idle(1'b1);
  endtask

  initial begin
    int   idx0, idx1, ncommit;
    ent_t h0, h1;
    logic h0_v, h1_v, r, fl;
    logic `RS_INT_ADDR_BUS seen [$];

    rst = 1'b0;
    req0_valid = 1'b0; req0_rs_addr = '0; req0_exc_type = '0; req0_data = '0;
    req1_valid = 1'b0; req1_rs_addr = '0; req1_exc_type = '0; req1_data = '0;
`ifdef WB_INT_ARB_FLUSH_EN
    flush = 1'b0;
`endif
    m_last = (PRIO == 0); m_en = 1'b0; m_commit = '0;
    @(negedge clk);

    // Reset state: outputs cleared, ready low during reset
    idle(1'b0);
    check_eq("rst_en",   64'(commit_en),   64'd0);
    check_eq("rst_rdy0", 64'(req0_ready),  64'd0);
    check_eq("rst_data", 64'(commit_data), 64'd0);
    idle(1'b1);

    // Single uncontended request
    drive_cycle(1'b1, 1'b1, mk(4'd3, 3'd0, 32'h11), 1'b0, '0, 1'b0);
    check_eq("t1_en",   64'(commit_en),   64'd1);
    check_eq("t1_addr", 64'(commit_addr), 64'd3);
    check_eq("t1_data", 64'(commit_data), 64'h11);
    idle(1'b1);
    check_eq("t1_idle_en",   64'(commit_en),   64'd0);
    check_eq("t1_hold_addr", 64'(commit_addr), 64'd3);

    // Same-cycle contention
    do_reset();
    drive_cycle(1'b1, 1'b1, mk(4'd1, 3'd0, 32'hA1), 1'b1, mk(4'd2, 3'd0, 32'hB2), 1'b0);
    check_eq("t2_first",  64'(commit_addr), 64'd1);
    check_eq("t2_rdy1_0", 64'(req1_ready),  64'd0);
    idle(1'b1);
    check_eq("t2_second", 64'(commit_addr), 64'd2);
    check_eq("t2_sec_en", 64'(commit_en),   64'd1);
    idle(1'b1);

    // Both units streaming: addrs 0..5, req0 even, req1 odd
    do_reset();
    idx0 = 0; idx1 = 0; ncommit = 0;
    for (int c = 0; c < 20; c++) begin
      drive_cycle(1'b1, idx0 < 3, mk(4'(2 * idx0), 3'd0, 32'(idx0)),
                  idx1 < 3, mk(4'(2 * idx1 + 1), 3'd0, 32'(idx1)), 1'b0);
      if (m_acc0) idx0++;
      if (m_acc1) idx1++;
      if (commit_en) seen.push_back(commit_addr);
    end
    ncommit = seen.size();
    check_eq("t3_count", 64'(ncommit), 64'd6);
    for (int k = 0; k < 6; k++) begin
      if (k < ncommit) check_eq("t3_order", 64'(seen[k]), 64'(k));
    end

    // Exception passthrough
    drive_cycle(1'b1, 1'b0, '0, 1'b1, mk(4'd9, `EXC_TYPE_OV, 32'hFFFF_FFFF), 1'b0);
    check_eq("t4_exc",  64'(commit_exc_type), 64'(`EXC_TYPE_OV));
    check_eq("t4_data", 64'(commit_data),     64'hFFFF_FFFF);
    idle(1'b1);

    // Reset while slot1 is full
    drive_cycle(1'b1, 1'b1, mk(4'd7, 3'd1, 32'h7), 1'b1, mk(4'd8, 3'd1, 32'h8), 1'b0);
    idle(1'b0);
    check_eq("t5_no_commit", 64'(commit_en), 64'd0);
    idle(1'b1);
    check_eq("t5_no_commit2", 64'(commit_en), 64'd0);
    check_eq("t5_rdy0", 64'(req0_ready), 64'd1);
    check_eq("t5_rdy1", 64'(req1_ready), 64'd1);
    drive_cycle(1'b1, 1'b1, mk(4'd10, 3'd0, 32'h10), 1'b1, mk(4'd11, 3'd0, 32'h11), 1'b0);
    check_eq("t5_tie", 64'(commit_addr), 64'd10);
    idle(1'b1);

`ifdef WB_INT_ARB_FLUSH_EN
    // Flush drops a parked loser
    drive_cycle(1'b1, 1'b1, mk(4'd12, 3'd0, 32'h12), 1'b1, mk(4'd13, 3'd0, 32'h13), 1'b0);
    drive_cycle(1'b1, 1'b0, '0, 1'b0, '0, 1'b1);
    check_eq("t6_flush_en", 64'(commit_en), 64'd0);
    idle(1'b1);
    check_eq("t6_after_en", 64'(commit_en), 64'd0);
`endif

    // Randomized traffic with occasional reset and flush
    h0_v = 1'b0; h1_v = 1'b0; h0 = '0; h1 = '0;
    m_acc0 = 1'b0; m_acc1 = 1'b0; r = 1'b1;
    for (int c = 0; c < 600; c++) begin
      if (!h0_v || m_acc0 || !r) begin
        h0_v = ($urandom_range(0, 3) != 0);
        h0   = rnd_ent();
      end
      if (!h1_v || m_acc1 || !r) begin
        h1_v = ($urandom_range(0, 3) != 0);
        h1   = rnd_ent();
      end
      r  = ($urandom_range(0, 49) != 0);
      fl = ($urandom_range(0, 11) == 0);
      drive_cycle(r, h0_v, h0, h1_v, h1, fl);
    end
    idle(1'b1);
    idle(1'b1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/wb_int_arbiter.md
# wb_int_arbiter

Shares the single RS Int commit port between two integer execution units: requester 0 (ALU) and requester 1 (MDU, multiply/divide). Each unit has a one-entry hold slot, and round-robin arbitration picks one winner per cycle. The winner is committed through a registered output stage, with the same one-cycle latency as the integer write-back path. The block sits between the Int execution units and RS Int and replaces the direct unit-to-RS commit connection.

## Interface
Parameters:
- PRIO_INIT, default 0: requester that wins the first tie after reset (0 or 1).

Ports:
- clk  in  1  clock
- rst  in  1  reset, synchronous, active-low
- req0_valid  in  1  ALU result valid
- req0_ready  out  1  ALU may present a result this cycle
- req0_rs_addr  in  `RS_INT_ADDR_BUS  RS Int entry of the ALU result
- req0_exc_type  in  `EXC_TYPE_BUS  encoded exception of the ALU result
- req0_data  in  `DATA_BUS  ALU result
- req1_valid / req1_ready / req1_rs_addr / req1_exc_type / req1_data: same as req0_*, for the MDU
- flush  in  1  drop all pending results (only with WB_INT_ARB_FLUSH_EN)
- commit_en  out  1  commit strobe to RS Int
- commit_addr  out  `RS_INT_ADDR_BUS  RS Int entry being committed
- commit_exc_type  out  `EXC_TYPE_BUS  exception type, passed through unchanged
- commit_data  out  `DATA_BUS  committed result

## Operation
- Handshake:
  - reqN_ready = !slotN_full. It has no combinational dependence on reqN_valid.
  - A transfer happens when reqN_valid && reqN_ready.
  - A requester must hold its valid and payload stable while ready=0.
- Candidates:
  - candN = slotN_full | (reqN_valid & reqN_ready).
  - The source is the slot if it is full, otherwise the input bus (bypass).
- Arbitration:
  - Only one candidate: it wins.
  - Both candidates: the requester that was not granted last wins.
  - last_grant updates on every grant.
  - After reset, last_grant = !PRIO_INIT.
- Winner: its payload is registered onto commit_*, and commit_en=1 for that one cycle. A winning slot is cleared.
- Loser:
  - If the loser's source was the bypass, the payload is captured into its slot.
  - If the loser's source was the slot, the slot keeps its contents.
- No candidate: commit_en=0, and commit_addr/exc_type/data hold their last values.
- exc_type is not decoded. Excepting and normal results are arbitrated identically.
- Maximum one commit per cycle. A slot is never overwritten, because ready=0 while the slot is full.

## Timing
- Reset (rst=0 at a clk edge):
  - Both slots are emptied, last_grant = !PRIO_INIT, and all commit_* registers are cleared to 0.
  - req0_ready and req1_ready are forced to 0 while rst=0, and read 1 in the first cycle after reset deasserts.
  - Reset asserted mid-operation discards slot contents with no commit.
- Uncontended latency: a request accepted at edge T appears with commit_en=1 after edge T+1, which is 1 cycle.
- Contended: the loser commits exactly 1 cycle after the winner. Its ready is 0 for that one cycle.
- Both units valid every cycle: commits alternate 0,1,0,1 (with PRIO_INIT=0), and each unit sees ready toggle 1,0,1,0.
- Slot full with no competitor: the slot wins, commits next cycle, and ready returns to 1 in the cycle after the commit.

## Configuration
- WB_INT_ARB_FLUSH_EN defined:
  - The flush port exists.
  - flush=1 at an edge clears both slots, drops any request accepted that cycle, and forces commit_en=0 after that edge.
  - last_grant is unchanged.
  - reqN_ready is not gated by flush.
  - flush takes precedence over a simultaneous grant.
- Not defined: the flush port is absent, and pending results always commit.

## Test plan
- Reset, then req0 only (rs_addr=3, data=0x0000_0011): commit_en=1 with addr 3 and data 0x11 exactly one cycle later. In the following cycle commit_en=0 and the outputs hold.
- Same cycle req0 (addr 1) and req1 (addr 2), PRIO_INIT=0: addr 1 commits at T+1 and addr 2 at T+2. req1_ready=0 during T+1.
- Both units valid for 6 cycles with distinct addrs 0..5: commits alternate requesters, with no loss and no duplicates. Six commits in total, and the per-requester order is preserved.
- Exception passthrough: req1 with exc_type=`EXC_TYPE_OV and data 0xFFFF_FFFF: commit_exc_type=`EXC_TYPE_OV and data is unchanged.
- Reset asserted while slot1 is full: no commit follows, both ready signals are 1 after reset, and the next tie goes to PRIO_INIT.
- With WB_INT_ARB_FLUSH_EN: fill slot1 by contention, then assert flush: commit_en stays 0 and the slot1 entry never commits.
